// File: rtl/jk_bank_arbiter.sv
// Two-requester round-robin arbiter driving a shared bank of JK flip-flops.
// One command at a time: IDLE accepts, APPLY updates q, DONE pulses done and counts.

module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (en) begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end
endmodule

module jk_bank_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_mask,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_mask,
    output logic             req1_ready,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             grant_id,
    output logic             done,
    output logic [15:0]      cmd_count
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic             last_grant;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] mask_q;
    logic             win_id;
    logic             accept;

    // On a tie the requester that did not win last time goes next.
    assign win_id     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = (state == S_IDLE) && req0_valid && !win_id;
    assign req1_ready = (state == S_IDLE) && req1_valid && win_id;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cmd_count  <= 16'd0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            op_q       <= 2'b00;
            mask_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_APPLY;
                        grant_id   <= win_id;
                        last_grant <= win_id;
                        op_q       <= win_id ? req1_op : req0_op;
                        mask_q     <= win_id ? req1_mask : req0_mask;
                    end
                end
                S_APPLY: state <= S_DONE;
                S_DONE: begin
                    state     <= S_IDLE;
                    cmd_count <= cmd_count + 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Each bank bit is its own JK cell, enabled only in APPLY where its mask bit is set.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        jk_cell u_cell (
            .clk  (clk),
            .reset(reset),
            .en   ((state == S_APPLY) && mask_q[gi]),
            .j    (op_q[1]),
            .k    (op_q[0]),
            .q    (q[gi])
        );
    end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: a negedge model predicts readies, grants,
// q and cmd_count; expected completions are queued at acceptance and popped on done.

module tb_jk_bank_arbiter;
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TOG  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_op, req1_op;
    logic [7:0]  req0_mask, req1_mask;
    logic        req0_ready, req1_ready;
    logic [7:0]  q;
    logic        busy, grant_id, done;
    logic [15:0] cmd_count;

    jk_bank_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_op   (req0_op),
        .req0_mask (req0_mask),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_op   (req1_op),
        .req1_mask (req1_mask),
        .req1_ready(req1_ready),
        .q         (q),
        .busy      (busy),
        .grant_id  (grant_id),
        .done      (done),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        gid;
        logic [7:0]  q;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic        glog[$];
    int          ph       = 0;
    logic        last_m   = 1'b1;
    logic [7:0]  q_m      = 8'h00;
    logic [15:0] cnt_m    = 16'h0000;
    logic        cnt_pend = 1'b0;
    logic [15:0] cnt_exp;
    int          cyc      = 0;
    int          acc_n    = 0;
    int          last_acc = -1;
    bit          gap_chk  = 1'b0;

    // Reference model, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        logic       w, er0, er1;
        logic [1:0] op;
        logic [7:0] m;
        exp_t       e;
        cyc++;
        chk("busy", busy, ph != 0);
        chk("done", done, ph == 2);
        if (cnt_pend) begin
            chk("cmd_count", cmd_count, cnt_exp);
            cnt_pend = 1'b0;
        end
        if (!reset) begin
            ph = 0; last_m = 1'b1; q_m = 8'h00; cnt_m = 16'h0000; sb.delete();
        end else begin
            case (ph)
                0: begin
                    w   = (req0_valid && req1_valid) ? ~last_m : req1_valid;
                    er0 = req0_valid && !w;
                    er1 = req1_valid && w;
                    chk("rdy0", req0_ready, er0);
                    chk("rdy1", req1_ready, er1);
                    if (er0 || er1) begin
                        op = w ? req1_op : req0_op;
                        m  = w ? req1_mask : req0_mask;
                        for (int i = 0; i < 8; i++)
                            if (m[i])
                                case (op)
                                    OP_RST:  q_m[i] = 1'b0;
                                    OP_SET:  q_m[i] = 1'b1;
                                    OP_TOG:  q_m[i] = ~q_m[i];
                                    default: q_m[i] = q_m[i];
                                endcase
                        last_m = w;
                        sb.push_back('{w, q_m, cnt_m + 16'd1});
                        glog.push_back(w);
                        if (gap_chk && last_acc >= 0) chk("acc_gap", cyc - last_acc, 3);
                        last_acc = cyc;
                        acc_n++;
                        ph = 1;
                    end
                end
                1: begin
                    chk("rdy_apply", {req0_ready, req1_ready}, 2'b00);
                    ph = 2;
                end
                default: begin
                    chk("rdy_done", {req0_ready, req1_ready}, 2'b00);
                    if (sb.size() == 0) begin
                        chk("sb_nonempty", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        chk("q_done", q, e.q);
                        chk("grant_id", grant_id, e.gid);
                        chk("cnt_before", cmd_count, cnt_m);
                        cnt_exp  = e.cnt;
                        cnt_pend = 1'b1;
                        cnt_m    = e.cnt;
                    end
                    ph = 0;
                end
            endcase
        end
    end

    task automatic wait_acc(input int target);
        int t = 0;
        while (acc_n < target && t < 30) begin
            @(negedge clk); #1;
            t++;
        end
        chk("acc_timeout", acc_n >= target, 1);
    endtask

    task automatic drive(input int r, input logic [1:0] op, input logic [7:0] m);
        if (r == 0) begin req0_valid = 1'b1; req0_op = op; req0_mask = m; end
        else        begin req1_valid = 1'b1; req1_op = op; req1_mask = m; end
    endtask

    // Single command: accept, then return once the block is back in IDLE.
    task automatic send(input int r, input logic [1:0] op, input logic [7:0] m);
        int tgt;
        @(posedge clk); #1;
        tgt = acc_n + 1;
        drive(r, op, m);
        wait_acc(tgt);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int n0;
        reset = 1'b0;
        req0_valid = 1'b0; req0_op = OP_HOLD; req0_mask = 8'h00;
        req1_valid = 1'b0; req1_op = OP_HOLD; req1_mask = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_q", q, 8'h00);
        chk("rst_cnt", cmd_count, 16'h0000);
        chk("rst_gid", grant_id, 1'b0);

        send(0, OP_SET, 8'h0F);
        @(negedge clk);
        chk("set_q", q, 8'h0F);
        chk("set_cnt", cmd_count, 16'd1);

        send(1, OP_TOG, 8'hFF);
        send(1, OP_HOLD, 8'hFF);
        @(negedge clk);
        chk("hold_q", q, 8'hF0);
        chk("hold_cnt", cmd_count, 16'd3);

        send(1, OP_TOG, 8'h00);
        @(negedge clk);
        chk("zmask_q", q, 8'hF0);
        chk("zmask_cnt", cmd_count, 16'd4);

        // Round-robin with both requesters held valid.
        glog.delete();
        @(posedge clk); #1;
        gap_chk = 1'b1;
        last_acc = -1;
        n0 = acc_n;
        drive(0, OP_RST, 8'h01);
        drive(1, OP_SET, 8'h80);
        wait_acc(n0 + 4);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        gap_chk = 1'b0;
        chk("rr_n", glog.size(), 4);
        for (int i = 0; i < glog.size() && i < 4; i++) chk("rr_gid", glog[i], i % 2);

        // Reset landing in the APPLY cycle discards the command.
        @(posedge clk); #1;
        n0 = acc_n;
        drive(0, OP_SET, 8'hFF);
        wait_acc(n0 + 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_q", q, 8'h00);
        chk("mid_rst_cnt", cmd_count, 16'h0000);
        glog.delete();
        @(posedge clk); #1;
        n0 = acc_n;
        drive(0, OP_RST, 8'h01);
        drive(1, OP_SET, 8'h80);
        wait_acc(n0 + 1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        chk("tie_after_rst_n", glog.size(), 1);
        if (glog.size() > 0) chk("tie_after_rst", glog[0], 1'b0);

        // A one-cycle req1 pulse during APPLY must be ignored.
        @(posedge clk); #1;
        n0 = acc_n;
        drive(0, OP_TOG, 8'h3C);
        wait_acc(n0 + 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive(1, OP_SET, 8'hFF);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ignore_q", q, 8'h3C);
        chk("ignore_n", acc_n, n0 + 1);

        // Counter wrap from 0xFFFF.
        #1;
        force dut.cmd_count = 16'hFFFF;
        cnt_m = 16'hFFFF;
        #1;
        release dut.cmd_count;
        send(0, OP_SET, 8'h01);
        @(negedge clk);
        chk("wrap_cnt", cmd_count, 16'h0000);
        chk("wrap_q", q, 8'h3D);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, number of JK flip-flop bits in the shared bank.
REQ-002 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port: reset, input, 1, synchronous active-low reset; 0 sampled at a rising clk edge resets the block.
REQ-004 Port: req0_valid, input, 1, requester 0 has a command pending.
REQ-005 Port: req0_op, input, 2, requester 0 JK op: 00 HOLD (J=0,K=0); 01 RESET (J=0,K=1); 10 SET (J=1,K=0); 11 TOGGLE (J=1,K=1).
REQ-006 Port: req0_mask, input, WIDTH, bank bits affected by the requester 0 op.
REQ-007 Port: req0_ready, output, 1, requester 0 command accepted this cycle when req0_valid is also 1.
REQ-008 Ports: req1_valid, req1_op, req1_mask, req1_ready, same directions, widths and meanings for requester 1.
REQ-009 Port: q, output, WIDTH, current bank state.
REQ-010 Port: busy, output, 1, high while in APPLY or DONE.
REQ-011 Port: grant_id, output, 1, index of the requester whose command is in flight; holds its last value while idle.
REQ-012 Port: done, output, 1, one-cycle pulse when an accepted command has been applied to q.
REQ-013 Port: cmd_count, output, 16, number of completed commands, modulo 2^16.

Function
REQ-014 The FSM SHALL have three states: IDLE, APPLY and DONE.
REQ-015 In IDLE, the arbiter SHALL select a winner combinationally from req0_valid and req1_valid, and assert only the winner's ready.
REQ-016 If only one valid is high, that requester SHALL win.
REQ-017 If both valids are high, the requester not equal to last_grant SHALL win (round-robin).
REQ-018 Outside IDLE, req0_ready and req1_ready SHALL both be 0.
REQ-019 Handshake: valid&&ready at an edge SHALL latch the winner's op, mask and index, set grant_id and last_grant to the winner, and move IDLE->APPLY.
REQ-020 A requester SHALL keep valid, op and mask stable until its ready is seen; the block does not check this.
REQ-021 In APPLY, at the next edge each bit i with mask[i]=1 SHALL update per JK rules on the latched op: HOLD keeps q[i]; RESET drives 0; SET drives 1; TOGGLE drives ~q[i].
REQ-022 In APPLY, bits with mask[i]=0 SHALL be unchanged; the state then moves APPLY->DONE.
REQ-023 In DONE, done SHALL be 1 for exactly that cycle, cmd_count SHALL increment by 1 at the edge leaving DONE (0xFFFF wraps to 0x0000), and the state moves DONE->IDLE.
REQ-024 Timing: q changes at acceptance edge +1, done is high during acceptance edge +2, and the next acceptance is no earlier than acceptance edge +3.
REQ-025 A HOLD op or an all-zero mask SHALL still complete the full APPLY/DONE sequence and count as a command.
REQ-026 Valid deasserting while the block is busy SHALL have no effect; no command is queued, and only IDLE samples requests.
REQ-027 busy SHALL be (state != IDLE); done SHALL be (state == DONE).

Reset
REQ-028 With reset=0 at an edge, the block SHALL set state=IDLE, q=0, cmd_count=0, grant_id=0 and last_grant=1, so requester 0 wins the first tie.
REQ-029 Reset SHALL take priority in any state: a command in APPLY or DONE is discarded, q is not updated from it, done is not pulsed and cmd_count is not incremented.
REQ-030 During reset and on the first cycle after it, busy and done SHALL be 0; req0_ready and req1_ready follow REQ-015 from the first IDLE cycle after reset.

Verification
REQ-031 Single requester: after reset, req0 SET with mask 0x0F -> q=0x0F at acceptance +1, done pulse at +2, cmd_count=1.
REQ-032 Toggle and hold: with q=0x0F, req1 TOGGLE mask 0xFF gives q=0xF0; then req1 HOLD mask 0xFF gives q still 0xF0, done pulses, and cmd_count increments.
REQ-033 Round-robin: both valid continuously, req0 RESET 0x01 and req1 SET 0x80, for 4 commands -> grants 0,1,0,1, ready is never high for both, and accept edges are 3 cycles apart.
REQ-034 Reset mid-operation: reset=0 in the APPLY cycle of a SET 0xFF -> q=0, no done, cmd_count=0; the next tie is granted to req0.
REQ-035 Wrap-around: preload 65535 completed commands (or force cmd_count=0xFFFF), then complete one more -> cmd_count=0x0000 with a normal done pulse.
REQ-036 Busy ignores requests: req1 pulses valid for one cycle during APPLY of a req0 command -> req1_ready stays 0, and that command is never applied.
